uart_rx_stream: RTL and testbench

//  Serial UART receiver (8N1 by default) feeding the BIOS command parser over a valid/ready byte stream.

---
 rtl/uart_rx_stream_pkg.sv | 15 +
 rtl/uart_rx_stream_fifo.sv | 62 ++++++
 rtl/uart_rx_stream.sv | 136 +++++++++++++
 tb/tb_uart_rx_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_stream_pkg.sv
// Shared types and constants for the UART receive path.
// Imported by the receiver top and its byte FIFO.
package uart_rx_stream_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } uart_rx_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_stream_fifo.sv
// Small synchronous FIFO with clock enable; push is accepted when full
// only if a pop happens in the same cycle.
module byte_fifo
    import uart_rx_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (clk_en && w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clk_en) begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a byte
// FIFO presenting received characters on a valid/ready stream.
module uart_rx_stream
    import uart_rx_stream_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    uart_rx_state_t       r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_pop;
    logic                 w_push;

    assign w_pop  = i_ready & ~w_empty;
    assign w_push = (r_state == RX_STOP) && (r_cnt == CNT_LAST) && r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RX_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (clk_en) begin
            r_sync1     <= i_rx;
            r_sync2     <= r_sync1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            unique case (r_state)
                RX_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
                        if (r_idx == IDX_LAST) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_sync2) begin
                            r_overrun <= w_full & ~w_pop;
                            r_state   <= RX_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= RX_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_BREAK: begin
                    // a held-low line must return high before re-arming
                    if (r_sync2) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    byte_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .i_push  (w_push),
        .i_data  (r_shift),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign o_valid     = ~w_empty;
    assign o_data      = o_valid ? w_head : '0;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream: directed frames, expected bytes
// queued at send time and checked by an independent output monitor.
module tb_uart_rx_stream;

    localparam int C  = 16;
    localparam int DB = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b1;
    logic          i_rx = 1'b1;
    logic          i_ready = 1'b0;
    logic [DB-1:0] o_data;
    logic          o_valid;
    logic          o_frame_err;
    logic          o_overrun;
    logic          o_busy;

    int         checks = 0;
    int         failures = 0;
    int         n_rx = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    bit         gate3 = 1'b0;
    int         ph = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_stream #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (DB),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // enable pattern: always on, or one cycle in three
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gate3) begin
                ph = (ph + 1) % 3;
                clk_en = (ph == 0);
            end else begin
                clk_en = 1'b1;
            end
        end
    end

    // output monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && clk_en) begin
            if (o_valid && i_ready) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none",
                             o_data);
                end else begin
                    check("rx_byte", {24'h0, o_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (o_frame_err) n_ferr++;
            if (o_overrun) n_ovr++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (clk_en) k++;
        end
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d, input logic stopb,
                             input int nbits);
        logic [9:0] fr;
        fr = {stopb, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            i_rx = fr[i];
            wait_en(C);
        end
    endtask

    initial begin
        int         lat;
        int         base;
        bit         seen;
        logic [7:0] msg [4];
        logic [7:0] five [5];
        msg  = '{8'h62, 8'h6F, 8'h6F, 8'h74};
        five = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // reset state
        wait_cycles(3);
        check("rst_valid", {31'h0, o_valid}, 0);
        check("rst_data", {24'h0, o_data}, 0);
        check("rst_busy", {31'h0, o_busy}, 0);
        check("rst_ferr", {31'h0, o_frame_err}, 0);
        check("rst_ovr", {31'h0, o_overrun}, 0);
        rst = 1'b0;
        wait_cycles(2);

        // single byte with latency measurement
        i_ready = 1'b1;
        exp_q.push_back(8'h62);
        lat  = 0;
        seen = 1'b0;
        fork
            send_bits(8'h62, 1'b1, 10);
            begin
                while (!seen && lat < 400) begin
                    @(posedge clk);
                    lat++;
                    #1;
                    if (o_valid) seen = 1'b1;
                end
            end
        join
        check("latency", lat, 3 + C/2 + 9*C);
        wait_cycles(C);
        check("t1_busy", {31'h0, o_busy}, 0);
        check("t1_drained", exp_q.size(), 0);
        check("t1_ferr", n_ferr, 0);

        // "boot" buffered under back-pressure
        i_ready = 1'b0;
        foreach (msg[i]) begin
            exp_q.push_back(msg[i]);
            send_bits(msg[i], 1'b1, 10);
        end
        wait_cycles(5);
        check("t2_valid", {31'h0, o_valid}, 1);
        check("t2_head", {24'h0, o_data}, 32'h62);
        base = n_rx;
        i_ready = 1'b1;
        wait_cycles(4);
        check("t2_burst", n_rx - base, 4);
        check("t2_empty", {31'h0, o_valid}, 0);
        check("t2_ovr", n_ovr, 0);

        // five bytes into a four-deep buffer
        i_ready = 1'b0;
        foreach (five[i]) begin
            if (i < FD) exp_q.push_back(five[i]);
            send_bits(five[i], 1'b1, 10);
        end
        wait_cycles(2);
        check("t3_ovr", n_ovr, 1);
        check("t3_head", {24'h0, o_data}, 32'h11);
        i_ready = 1'b1;
        wait_cycles(6);
        check("t3_drained", exp_q.size(), 0);
        check("t3_ovr_once", n_ovr, 1);

        // bad stop bit followed by a held-low line
        base = n_rx;
        send_bits(8'h55, 1'b0, 10);
        wait_cycles(40);
        check("t4_ferr", n_ferr, 1);
        check("t4_break_busy", {31'h0, o_busy}, 1);
        i_rx = 1'b1;
        wait_cycles(5);
        check("t4_idle", {31'h0, o_busy}, 0);
        check("t4_no_push", n_rx - base, 0);
        check("t4_valid", {31'h0, o_valid}, 0);

        // short glitch is a false start
        i_rx = 1'b0;
        wait_cycles(4);
        i_rx = 1'b1;
        wait_cycles(2);
        check("t5_start_busy", {31'h0, o_busy}, 1);
        wait_cycles(20);
        check("t5_idle", {31'h0, o_busy}, 0);
        check("t5_valid", {31'h0, o_valid}, 0);
        check("t5_ferr", n_ferr, 1);
        check("t5_ovr", n_ovr, 1);

        // gated clock enable, then reset mid-frame
        gate3   = 1'b1;
        i_ready = 1'b0;
        wait_cycles(3);
        send_bits(8'hA7, 1'b1, 10);
        wait_en(2);
        check("t6_valid", {31'h0, o_valid}, 1);
        check("t6_data", {24'h0, o_data}, 32'hA7);
        send_bits(8'h3C, 1'b1, 4);
        check("t6_mid_busy", {31'h0, o_busy}, 1);
        i_rx = 1'b1;
        wait_cycles(1);
        rst = 1'b1;
        wait_cycles(3);
        check("t6_rst_valid", {31'h0, o_valid}, 0);
        check("t6_rst_data", {24'h0, o_data}, 0);
        check("t6_rst_busy", {31'h0, o_busy}, 0);
        check("t6_rst_ferr", {31'h0, o_frame_err}, 0);
        check("t6_rst_ovr", {31'h0, o_overrun}, 0);
        rst = 1'b0;
        wait_en(2);
        check("t6_fifo_empty", {31'h0, o_valid}, 0);
        i_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_bits(8'h5A, 1'b1, 10);
        wait_en(4);
        check("t6_rearm", exp_q.size(), 0);
        gate3 = 1'b0;
        wait_cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
